// File: rtl/semaforo_leds_multi.sv
// Multi-approach traffic-light lamp decoder with shared blink timebase, night mode and green-conflict fault latch.
// Optional macro SEMAF_SYNC_EN adds 2-flop synchronizers on semaf_in, night_mode and fault_clr.
module semaforo_leds_multi #(
    parameter int NUM_CH    = 2,
    parameter int BLINK_DIV = 12500000,
    parameter int FAULT_CYC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*NUM_CH-1:0]   semaf_in,
    input  logic                  night_mode,
    input  logic                  fault_clr,
    output logic [4*NUM_CH-1:0]   semaf_out,
    output logic                  blink_phase,
    output logic                  fault
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam int CW = $clog2(FAULT_CYC + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [CW-1:0] FAULT_LAST = CW'(FAULT_CYC - 1);
    localparam logic [CW-1:0] FAULT_MAX  = CW'(FAULT_CYC);

    logic [3*NUM_CH-1:0] semaf_s;
    logic                night_s;
    logic                clr_s;
    logic                conflict_s;
    logic                seen_s;
    logic [CW-1:0]       conf_cnt_next_s;
    logic                fault_next_s;
    logic [4*NUM_CH-1:0] lamps_next_s;

    logic [BW-1:0]       blink_cnt_r;
    logic                blink_phase_r;
    logic [CW-1:0]       conf_cnt_r;
    logic                fault_r;
    logic [4*NUM_CH-1:0] semaf_out_r;

    // Lamp pattern for one head; 'on' is the current blink phase.
    function automatic logic [3:0] decode_lamps(input logic [2:0] code, input logic on);
        logic [3:0] lamps;
        case (code)
            3'b000:  lamps = 4'b1100;
            3'b001:  lamps = on ? 4'b1100 : 4'b0100;
            3'b010:  lamps = on ? 4'b1100 : 4'b0000;
            3'b011:  lamps = 4'b0100;
            3'b100:  lamps = on ? 4'b0100 : 4'b0000;
            3'b101:  lamps = 4'b0010;
            3'b110:  lamps = 4'b0001;
            3'b111:  lamps = 4'b1111;
            default: lamps = 4'b0000;
        endcase
        return lamps;
    endfunction

`ifdef SEMAF_SYNC_EN
    logic [3*NUM_CH-1:0] semaf_meta_r, semaf_sync_r;
    logic                night_meta_r, night_sync_r;
    logic                clr_meta_r, clr_sync_r;

    // Two-flop synchronizers for the asynchronous control inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            semaf_meta_r <= '0;
            semaf_sync_r <= '0;
            night_meta_r <= 1'b0;
            night_sync_r <= 1'b0;
            clr_meta_r   <= 1'b0;
            clr_sync_r   <= 1'b0;
        end else begin
            semaf_meta_r <= semaf_in;
            semaf_sync_r <= semaf_meta_r;
            night_meta_r <= night_mode;
            night_sync_r <= night_meta_r;
            clr_meta_r   <= fault_clr;
            clr_sync_r   <= clr_meta_r;
        end
    end

    assign semaf_s = semaf_sync_r;
    assign night_s = night_sync_r;
    assign clr_s   = clr_sync_r;
`else
    assign semaf_s = semaf_in;
    assign night_s = night_mode;
    assign clr_s   = fault_clr;
`endif

    // Free-running blink timebase shared by every head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + BW'(1);
            blink_phase_r <= blink_phase_r;
        end
    end

    // A conflict is two or more heads showing a green-class code in the same cycle.
    always_comb begin
        seen_s     = 1'b0;
        conflict_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            conflict_s = conflict_s | (seen_s & (semaf_s[3*k +: 3] <= 3'd4));
            seen_s     = seen_s | (semaf_s[3*k +: 3] <= 3'd4);
        end
    end

    // Conflict run counter and fault latch; the clear dominates a simultaneous conflict.
    always_comb begin
        conf_cnt_next_s = conf_cnt_r;
        fault_next_s    = fault_r;
        if (clr_s) begin
            conf_cnt_next_s = '0;
            fault_next_s    = 1'b0;
        end else if (conflict_s) begin
            if (conf_cnt_r == FAULT_LAST) begin
                fault_next_s = 1'b1;
            end else begin
                fault_next_s = fault_r;
            end
            if (conf_cnt_r != FAULT_MAX) begin
                conf_cnt_next_s = conf_cnt_r + CW'(1);
            end else begin
                conf_cnt_next_s = conf_cnt_r;
            end
        end else begin
            conf_cnt_next_s = '0;
        end
    end

    // Next lamp image: fault override, then night flash, then per-head decode.
    always_comb begin
        lamps_next_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (fault_r) begin
                lamps_next_s[4*k +: 4] = blink_phase_r ? 4'b0001 : 4'b0000;
            end else if (night_s) begin
                lamps_next_s[4*k +: 4] = blink_phase_r ? 4'b0010 : 4'b0000;
            end else begin
                lamps_next_s[4*k +: 4] = decode_lamps(semaf_s[3*k +: 3], blink_phase_r);
            end
        end
    end

    // Monitor state and registered lamp outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conf_cnt_r  <= '0;
            fault_r     <= 1'b0;
            semaf_out_r <= '0;
        end else begin
            conf_cnt_r  <= conf_cnt_next_s;
            fault_r     <= fault_next_s;
            semaf_out_r <= lamps_next_s;
        end
    end

    assign semaf_out   = semaf_out_r;
    assign blink_phase = blink_phase_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_semaforo_leds_multi.sv
// Randomized and directed bench for semaforo_leds_multi against a cycle-count based reference model.
module tb_semaforo_leds_multi;

    localparam int NUM_CH    = 2;
    localparam int BLINK_DIV = 4;
    localparam int FAULT_CYC = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [3*NUM_CH-1:0] semaf_in = '0;
    logic                night_mode = 1'b0;
    logic                fault_clr = 1'b0;
    logic [4*NUM_CH-1:0] semaf_out;
    logic                blink_phase;
    logic                fault;

    int checks = 0;
    int errors = 0;

    logic [3:0] lamp_on  [8] = '{4'b1100, 4'b1100, 4'b1100, 4'b0100, 4'b0100, 4'b0010, 4'b0001, 4'b1111};
    logic [3:0] lamp_off [8] = '{4'b1100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0001, 4'b1111};

    // Model state: edges since reset release, fault latch, conflict run length, expected lamps.
    int                  n_m;
    bit                  fault_m;
    int                  run_m;
    logic [4*NUM_CH-1:0] out_m;
    logic [3*NUM_CH-1:0] code_h1, code_h2;
    bit                  night_h1, night_h2, clr_h1, clr_h2;

    semaforo_leds_multi #(
        .NUM_CH(NUM_CH), .BLINK_DIV(BLINK_DIV), .FAULT_CYC(FAULT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .semaf_in(semaf_in), .night_mode(night_mode),
        .fault_clr(fault_clr), .semaf_out(semaf_out), .blink_phase(blink_phase), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_m = 0; fault_m = 0; run_m = 0; out_m = '0;
        code_h1 = '0; code_h2 = '0;
        night_h1 = 0; night_h2 = 0; clr_h1 = 0; clr_h2 = 0;
    endtask

    function automatic bit phase_at(input int n);
        return ((n / BLINK_DIV) % 2) == 0;
    endfunction

    // One clock: predict from pre-edge inputs, clock, then compare all outputs.
    task automatic step(input string tag);
        logic [3*NUM_CH-1:0] codes;
        logic [4*NUM_CH-1:0] nxt;
        bit nm, clr, ph;
        int greens, c;
`ifdef SEMAF_SYNC_EN
        codes = code_h2; nm = night_h2; clr = clr_h2;
        code_h2 = code_h1; night_h2 = night_h1; clr_h2 = clr_h1;
        code_h1 = semaf_in; night_h1 = night_mode; clr_h1 = fault_clr;
`else
        codes = semaf_in; nm = night_mode; clr = fault_clr;
`endif
        ph = phase_at(n_m);
        greens = 0;
        nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = int'(codes[3*k +: 3]);
            if (c <= 4) greens++;
            if (fault_m)   nxt[4*k +: 4] = ph ? 4'b0001 : 4'b0000;
            else if (nm)   nxt[4*k +: 4] = ph ? 4'b0010 : 4'b0000;
            else           nxt[4*k +: 4] = ph ? lamp_on[c] : lamp_off[c];
        end
        if (clr) begin
            run_m = 0; fault_m = 0;
        end else if (greens >= 2) begin
            if (run_m < FAULT_CYC) run_m++;
            if (run_m == FAULT_CYC) fault_m = 1;
        end else begin
            run_m = 0;
        end
        out_m = nxt;
        n_m++;
        @(posedge clk);
        #1;
        check({tag, ".out"}, 32'(semaf_out), 32'(out_m));
        check({tag, ".phase"}, 32'(blink_phase), 32'(phase_at(n_m)));
        check({tag, ".fault"}, 32'(fault), 32'(fault_m));
    endtask

    task automatic cycles(input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) step(tag);
    endtask

    // Assert reset between edges, verify the immediate effect, release after one edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, ".rst_out"}, 32'(semaf_out), 32'h0);
        check({tag, ".rst_phase"}, 32'(blink_phase), 32'h1);
        check({tag, ".rst_fault"}, 32'(fault), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check({tag, ".rel_out"}, 32'(semaf_out), 32'h0);
        check({tag, ".rel_phase"}, 32'(blink_phase), 32'h1);
        check({tag, ".rel_fault"}, 32'(fault), 32'h0);
    endtask

    task automatic run_to_off_phase(input string tag);
        for (int i = 0; i < 2 * BLINK_DIV && phase_at(n_m); i++) step(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.out", 32'(semaf_out), 32'h0);
        check("reset.phase", 32'(blink_phase), 32'h1);
        check("reset.fault", 32'(fault), 32'h0);

        semaf_in = {3'b110, 3'b001}; cycles(16, "vfb");
        semaf_in = {3'b110, 3'b010}; cycles(16, "vbfb");
        semaf_in = {3'b110, 3'b100}; cycles(16, "vb");
        semaf_in = {3'b110, 3'b111}; cycles(8, "test");

        semaf_in = {3'b110, 3'b011}; night_mode = 1'b1; cycles(10, "night");
        night_mode = 1'b0; cycles(4, "day");

        semaf_in = {3'b000, 3'b011}; cycles(2, "conf2");
        semaf_in = {3'b110, 3'b011}; cycles(2, "noconf");
`ifndef SEMAF_SYNC_EN
        check("conf2.nofault", 32'(fault), 32'h0);
`endif
        semaf_in = {3'b000, 3'b011}; cycles(3, "conf3");
`ifndef SEMAF_SYNC_EN
        check("conf3.fault", 32'(fault), 32'h1);
`endif
        night_mode = 1'b1; cycles(10, "fault_night");
        night_mode = 1'b0;

        semaf_in = {3'b110, 3'b011}; fault_clr = 1'b1; step("clr");
        fault_clr = 1'b0; cycles(4, "after_clr");
`ifndef SEMAF_SYNC_EN
        check("clr.fault", 32'(fault), 32'h0);
        check("clr.out", 32'(semaf_out), 32'h14);
`endif
        semaf_in = {3'b000, 3'b011}; cycles(4, "refault");
        fault_clr = 1'b1; step("clr_conf");
        fault_clr = 1'b0; cycles(2, "clr_conf2");
`ifndef SEMAF_SYNC_EN
        check("clr_conf.nofault", 32'(fault), 32'h0);
`endif
        step("clr_conf3");
`ifndef SEMAF_SYNC_EN
        check("clr_conf.fault", 32'(fault), 32'h1);
`endif
        cycles(4, "fault_hold");

        run_to_off_phase("to_off");
        async_reset("rst_fault");
        semaf_in = {3'b110, 3'b001}; cycles(3, "post_rst");
        run_to_off_phase("to_off2");
        async_reset("rst_blink");

        for (int i = 0; i < 600; i++) begin
            semaf_in   = 6'($urandom);
            night_mode = ($urandom_range(0, 7) == 0);
            fault_clr  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            else step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/semaforo_leds_multi.md
Name: semaforo_leds_multi

Overview:
- Parametrised, multi-channel successor to the single-approach traffic-light code-to-lamp decoder.
- Takes one 3-bit phase code per approach and drives one 4-lamp head per approach: arrow, green, amber, red.
- Adds a shared programmable blink timebase, a night mode (all heads flash amber), and a green-conflict monitor that latches a fault and forces all heads to flash red.
- Sits between the intersection sequencer FSM and the board LED pins.

Parameters:
- NUM_CH, 2, number of approaches/lamp heads (1..8).
- BLINK_DIV, 12500000, clock cycles per blink half-period (>=2).
- FAULT_CYC, 3, consecutive conflict cycles required to latch a fault (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- semaf_in  in  3*NUM_CH  phase code; channel k is bits [3k+2:3k].
- night_mode  in  1  forces flashing amber on all heads.
- fault_clr  in  1  synchronous clear of the latched fault.
- semaf_out  out  4*NUM_CH  lamps for channel k at bits [4k+3:4k]: bit3 arrow, bit2 green, bit1 amber, bit0 red.
- blink_phase  out  1  current blink phase; 1 = lamps on.
- fault  out  1  latched conflict fault.

Behaviour:
- Reset (async, any time, including mid-blink or mid-fault): semaf_out = all 0; blink_phase = 1; blink counter = 0; conflict counter = 0; fault = 0. Reset release produces no glitch state.
- Blink timebase:
  - The counter runs freely from 0 to BLINK_DIV-1 and then wraps to 0.
  - On the wrap cycle, blink_phase toggles.
  - A full blink period is 2*BLINK_DIV cycles.
  - The timebase is shared by all channels, so every head blinks in lockstep. It is independent of input codes and never restarts on a code change.
- Code decode per channel (on = blink_phase 1, off = blink_phase 0):
  - 000 VF: 1100.
  - 001 VFb: on 1100, off 0100.
  - 010 VbFb: on 1100, off 0000.
  - 011 V: 0100.
  - 100 Vb: on 0100, off 0000.
  - 101 AMA: 0010.
  - 110 ROJ: 0001.
  - 111 TEST: 1111.
- Conflict monitor:
  - A channel is "green-class" when its code is 000..100.
  - A conflict exists in a cycle when two or more channels are green-class.
  - The conflict counter increments on each conflict cycle, saturating at FAULT_CYC. It returns to 0 on any non-conflict cycle.
  - fault sets on the clock edge where the counter would reach FAULT_CYC and stays set until fault_clr or rst.
  - With NUM_CH=1 a conflict is impossible; fault stays 0.
- fault_clr: while high, fault = 0 and the conflict counter = 0. If the conflict persists after fault_clr drops, counting restarts from 0.
- Output priority, highest first:
  1. rst
  2. fault: all heads 0001 when on, 0000 when off
  3. night_mode: all heads 0010 when on, 0000 when off
  4. per-channel decode
- Latency: semaf_out is registered. It reflects semaf_in, night_mode, fault and blink_phase as sampled one clock earlier. A change on semaf_in appears on semaf_out after 1 cycle.
- Simultaneous events:
  - A code change on the blink-toggle edge decodes using the pre-toggle phase value.
  - When fault sets, the fault override appears on the following cycle.
  - fault_clr and a conflict in the same cycle: the clear wins.

Optional Feature:
- Macro SEMAF_SYNC_EN.
- Defined: semaf_in, night_mode and fault_clr each pass through a 2-flop synchronizer, reset to 0, before use. Input-to-output latency becomes 3 cycles. Conflict detection uses the synchronized codes.
- Undefined: inputs are used directly; latency is 1 cycle.

Test Plan:
- Reset and blink, NUM_CH=2, BLINK_DIV=4. After rst release: blink_phase=1. blink_phase toggles every 4 cycles (period 8). semaf_out=8'h00 until the first code is sampled.
- Blink decode: ch0=001, ch1=110. Expect ch0 alternating 1100/0100 with a 4-cycle dwell; ch1 steady 0001. Repeat with ch0=010 (1100/0000), ch0=100 (0100/0000), ch0=111 (1111).
- Night mode: assert night_mode with ch0=011, ch1=110. Next cycle both heads show 0010/0000 in phase. Deassert night_mode: next cycle ch0=0100, ch1=0001.
- Conflict, FAULT_CYC=3:
  - ch0=011, ch1=000 for 2 cycles, then ch1=110: fault stays 0.
  - Hold the conflict for 3 cycles: fault=1 on the 3rd edge. Next cycle both heads flash 0001/0000, and this overrides night_mode.
- fault_clr: pulse 1 cycle with no conflict present. fault=0 and normal decode resumes the next cycle. Repeat with the conflict held: fault re-sets 3 cycles after fault_clr drops.
- Async reset mid-fault and mid-blink (off phase): outputs go to 0 immediately without a clock edge. blink_phase=1 and fault=0 after release.
